// File: rtl/mbus_wake_seq_pkg.sv
// mbus_wake_seq_pkg: sequencer state encoding and isolation-control levels
package mbus_wake_seq_pkg;
  typedef enum logic [2:0] {
    SLEEP      = 3'd0,
    INT_ASSERT = 3'd1,
    POWER_UP   = 3'd2,
    RELEASE    = 3'd3,
    ACTIVE     = 3'd4,
    ISO_ENTER  = 3'd5
  } state_e;
  localparam logic IO_HOLD    = 1'b0;
  localparam logic IO_RELEASE = 1'b1;
endpackage

// File: rtl/mbus_wake_seq_sync2.sv
// mbus_wake_seq_sync2: two-flop synchroniser with selectable reset level
// Ports: clk_i/rst_i clock and sync active-high reset, d_i async input, q_o synchronised output.
module mbus_wake_seq_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic q1_q, q2_q;
  always_ff @(posedge clk_i)
    if (rst_i) {q2_q, q1_q} <= {RST_VAL, RST_VAL};
    else       {q2_q, q1_q} <= {q1_q, d_i};
  assign q_o = q2_q;
endmodule

// File: rtl/mbus_wake_seq.sv
// mbus_wake_seq: power/isolation sequencer for a power-gated MBus layer
// Ports: clk_i/rst_i clock and sync active-high reset; clkin_i async MBus clock line;
//   int_req_i local wake/bus request level; sleep_req_i sleep-entry pulse;
//   release_iso_o isolation control; external_int_o DOUT-low request; pwr_on_o power switch;
//   awake_o high in ACTIVE; int_timeout_err_o one-cycle pulse on interrupt timeout.
module mbus_wake_seq
  import mbus_wake_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int ISO_CYCLES    = 2,
  parameter int INT_TIMEOUT   = 255,
  parameter int CNT_W         = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clkin_i,
  input  logic int_req_i,
  input  logic sleep_req_i,
  output logic release_iso_o,
  output logic external_int_o,
  output logic pwr_on_o,
  output logic awake_o,
  output logic int_timeout_err_o
);
  // POWER_UP waits one cycle beyond SETTLE_CYCLES so isolation opens SETTLE_CYCLES+1 after power-on
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] ISO_LAST    = CNT_W'(ISO_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(INT_TIMEOUT - 1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic clkin_s, clkin_prev_q, clkin_edge;
  logic armed_q, armed_d, rel_d, ext_d, pwr_d, awake_d, err_d;
  mbus_wake_seq_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (clkin_i),
    .q_o  (clkin_s)
  );
  assign clkin_edge = clkin_s ^ clkin_prev_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    err_d   = 1'b0;
    // a timed-out request stays disarmed until int_req_i has been seen low
    armed_d = armed_q | ~int_req_i;
    case (state_q)
      SLEEP:
        if (int_req_i && armed_q) begin
          state_d = INT_ASSERT;
          cnt_d   = '0;
        end else if (clkin_edge) begin
          state_d = POWER_UP;
          cnt_d   = '0;
        end
      INT_ASSERT:
        if (clkin_edge) begin
          state_d = POWER_UP;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d = SLEEP;
          err_d   = 1'b1;
          armed_d = 1'b0;
        end
      POWER_UP:  state_d = (cnt_q == SETTLE_LAST) ? RELEASE : POWER_UP;
      RELEASE:   state_d = ACTIVE;
      ACTIVE:
        if (sleep_req_i) begin
          state_d = ISO_ENTER;
          cnt_d   = '0;
        end
      ISO_ENTER: state_d = (cnt_q == ISO_LAST) ? SLEEP : ISO_ENTER;
      default:   state_d = SLEEP;
    endcase
    // outputs are registered from the next state so they line up with the state they describe
    rel_d   = (state_d == RELEASE || state_d == ACTIVE) ? IO_RELEASE : IO_HOLD;
    pwr_d   = state_d != SLEEP && state_d != INT_ASSERT;
    awake_d = state_d == ACTIVE;
    // a bus request raised before wake keeps DOUT low through power-up
    ext_d   = state_d == INT_ASSERT || (state_d == POWER_UP && external_int_o);
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q           <= SLEEP;
      cnt_q             <= '0;
      armed_q           <= 1'b1;
      clkin_prev_q      <= 1'b1;
      release_iso_o     <= IO_HOLD;
      external_int_o    <= 1'b0;
      pwr_on_o          <= 1'b0;
      awake_o           <= 1'b0;
      int_timeout_err_o <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      armed_q           <= armed_d;
      clkin_prev_q      <= clkin_s;
      release_iso_o     <= rel_d;
      external_int_o    <= ext_d;
      pwr_on_o          <= pwr_d;
      awake_o           <= awake_d;
      int_timeout_err_o <= err_d;
    end
endmodule

// File: tb/tb_mbus_wake_seq.sv
// tb_mbus_wake_seq: randomized and directed check of mbus_wake_seq against a timestamp-based model
module tb_mbus_wake_seq;
  import mbus_wake_seq_pkg::*;
  localparam int SETTLE = 8;
  localparam int ISO    = 2;
  localparam int TMO    = 16;
  logic clk = 1'b0;
  logic rst, clkin, int_req, sleep_req;
  logic release_iso, external_int, pwr_on, awake, int_timeout_err;
  always #5 clk = ~clk;
  mbus_wake_seq #(
    .SETTLE_CYCLES(SETTLE),
    .ISO_CYCLES   (ISO),
    .INT_TIMEOUT  (TMO),
    .CNT_W        (8)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .clkin_i          (clkin),
    .int_req_i        (int_req),
    .sleep_req_i      (sleep_req),
    .release_iso_o    (release_iso),
    .external_int_o   (external_int),
    .pwr_on_o         (pwr_on),
    .awake_o          (awake),
    .int_timeout_err_o(int_timeout_err)
  );
  typedef enum {M_OFF, M_REQ, M_WARM, M_ON, M_ISO} mode_t;
  mode_t mode = M_OFF;
  int n_chk = 0, n_err = 0;
  int cyc = 0, t0 = 0;
  bit armed = 1, by_int = 0, m_err = 0;
  bit h1 = 1, h2 = 1, h3 = 1;
  bit last_rst = 0;
  int pwr_run = 0, hold_run = 0, pwr_rise = 0, err_cnt = 0;
  logic prev_rel = IO_HOLD, prev_pwr = 1'b0;
  logic ck = 1'b1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask
  // wake phases tracked by entry timestamp; clkin edges seen through a 3-sample history
  task automatic model_step();
    bit e;
    cyc++;
    last_rst = rst;
    if (rst) begin
      mode = M_OFF; armed = 1; by_int = 0; m_err = 0;
      h1 = 1; h2 = 1; h3 = 1;
      return;
    end
    e  = h2 != h3;
    h3 = h2; h2 = h1; h1 = clkin;
    m_err = 0;
    case (mode)
      M_OFF:
        if (int_req && armed) begin mode = M_REQ; t0 = cyc; end
        else if (e) begin mode = M_WARM; t0 = cyc; by_int = 0; end
      M_REQ:
        if (e) begin mode = M_WARM; t0 = cyc; by_int = 1; end
        else if (cyc - t0 == TMO) begin mode = M_OFF; m_err = 1; end
      M_WARM: if (cyc - t0 == SETTLE + 1) begin mode = M_ON; t0 = cyc; end
      M_ON:   if (sleep_req && cyc - t0 >= 2) begin mode = M_ISO; t0 = cyc; end
      M_ISO:  if (cyc - t0 == ISO) mode = M_OFF;
      default: mode = M_OFF;
    endcase
    armed = m_err ? 1'b0 : (armed | !int_req);
  endtask
  task automatic compare();
    check("pwr_on", pwr_on, mode inside {M_WARM, M_ON, M_ISO});
    check("release_iso", release_iso, (mode == M_ON) ? IO_RELEASE : IO_HOLD);
    check("awake", awake, mode == M_ON && cyc - t0 >= 1);
    check("external_int", external_int, mode == M_REQ || (mode == M_WARM && by_int));
    check("timeout_err", int_timeout_err, m_err);
    if (int_timeout_err === 1'b1) err_cnt++;
    if (pwr_on === 1'b1 && prev_pwr !== 1'b1) pwr_rise = cyc;
    if (release_iso === IO_RELEASE && prev_rel !== IO_RELEASE) begin
      check("iso_settle", pwr_run >= SETTLE, 1);
      check("rel_latency", cyc - pwr_rise, SETTLE + 1);
    end
    if (pwr_on === 1'b0 && prev_pwr === 1'b1 && !last_rst)
      check("iso_before_off", hold_run >= ISO, 1);
    pwr_run  = (pwr_on === 1'b1) ? pwr_run + 1 : 0;
    hold_run = (release_iso === IO_HOLD) ? hold_run + 1 : 0;
    prev_pwr = pwr_on;
    prev_rel = release_iso;
  endtask
  task automatic step(input logic r, input logic i, input logic s);
    rst = r; clkin = ck; int_req = i; sleep_req = s;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask
  initial begin
    rst = 1'b1; clkin = 1'b1; int_req = 1'b0; sleep_req = 1'b0;
    repeat (2) step(1, 0, 0);
    repeat (20) step(0, 0, 0);
    check("idle_iso", release_iso, IO_HOLD);
    repeat (10) step(0, 1, 0);
    ck = ~ck;
    repeat (20) step(0, 1, 0);
    check("int_wake_awake", awake, 1);
    step(0, 0, 1);
    check("sleep_iso_next", release_iso, IO_HOLD);
    repeat (5) step(0, 0, 0);
    check("slept_pwr", pwr_on, 0);
    err_cnt = 0;
    repeat (25) step(0, 1, 0);
    check("tmo_pulses", err_cnt, 1);
    check("no_retrigger", external_int, 0);
    step(0, 0, 0);
    ck = ~ck;
    repeat (5) step(0, 0, 0);
    step(0, 0, 1);
    repeat (15) step(0, 0, 0);
    check("bus_wake_awake", awake, 1);
    step(0, 0, 1);
    repeat (4) step(0, 0, 0);
    ck = ~ck;
    repeat (6) step(0, 0, 0);
    step(1, 0, 0);
    check("rst_pu_pwr", pwr_on, 0);
    repeat (3) step(0, 0, 0);
    ck = ~ck;
    repeat (16) step(0, 0, 0);
    step(0, 0, 1);
    step(1, 0, 0);
    check("rst_iso_awake", awake, 0);
    repeat (3) step(0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 29) == 0) ck = ~ck;
      if ($urandom_range(0, 39) == 0) int_req = ~int_req;
      step($urandom_range(0, 199) == 0, int_req, $urandom_range(0, 9) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
